// File: rtl/tdc_sequencer.sv
// Measurement sequencer for a carry-chain TDC: arms the chain, counts coarse
// cycles, turns the captured thermometer code into a {timeout, overflow, coarse, fine} stamp.
module tdc_sequencer #(
    parameter int STAGES   = 64,
    parameter int COARSE_W = 16,
    parameter int TIMEOUT  = 1024,
    parameter int FINE_W   = $clog2(STAGES + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         arm,
    input  logic [STAGES-1:0]            thermo,
    output logic                         tdc_reset,
    output logic                         busy,
    output logic [COARSE_W+FINE_W+1:0]   stamp_data,
    output logic                         stamp_valid,
    input  logic                         stamp_ready
);

    localparam int STAMP_W = COARSE_W + FINE_W + 2;
    localparam logic [COARSE_W-1:0] COARSE_LAST = COARSE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic [STAGES-1:0]   snap_thermo_q, snap_thermo_d;
    logic [COARSE_W-1:0] snap_coarse_q, snap_coarse_d;
    logic [STAMP_W-1:0]  stamp_q, stamp_d;
    logic [FINE_W-1:0]   fine_cnt;
    logic                hit;

    assign hit = |thermo;

    // Population count rather than leading-one: bubbles in the chain still
    // contribute the correct number of elapsed stages.
    always_comb begin
        fine_cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            fine_cnt = fine_cnt + FINE_W'(snap_thermo_q[i]);
        end
    end

    always_comb begin
        state_d       = state_q;
        coarse_d      = coarse_q;
        snap_thermo_d = snap_thermo_q;
        snap_coarse_d = snap_coarse_q;
        stamp_d       = stamp_q;
        unique case (state_q)
            IDLE: begin
                if (arm && !hit) begin
                    state_d  = ARMED;
                    coarse_d = '0;
                end
            end
            ARMED: begin
                // A hit wins over a simultaneous timeout.
                if (hit) begin
                    snap_thermo_d = thermo;
                    snap_coarse_d = coarse_q;
                    state_d       = CAPTURE;
                end else if (coarse_q == COARSE_LAST) begin
                    stamp_d = {1'b1, 1'b0, COARSE_LAST, {FINE_W{1'b0}}};
                    state_d = PRESENT;
                end else begin
                    coarse_d = coarse_q + 1'b1;
                end
            end
            CAPTURE: begin
                stamp_d = {1'b0, &snap_thermo_q, snap_coarse_q, fine_cnt};
                state_d = PRESENT;
            end
            PRESENT: begin
                if (stamp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            coarse_q      <= '0;
            snap_thermo_q <= '0;
            snap_coarse_q <= '0;
            stamp_q       <= '0;
        end else begin
            state_q       <= state_d;
            coarse_q      <= coarse_d;
            snap_thermo_q <= snap_thermo_d;
            snap_coarse_q <= snap_coarse_d;
            stamp_q       <= stamp_d;
        end
    end

    // Outputs decode straight from registered state: no ready-to-valid path.
    assign tdc_reset   = (state_q != ARMED);
    assign busy        = (state_q != IDLE);
    assign stamp_valid = (state_q == PRESENT);
    assign stamp_data  = stamp_q;

endmodule

// File: tb/tb_tdc_sequencer.sv
// Directed bench for tdc_sequencer with STAGES=8, TIMEOUT=16, COARSE_W=16.
module tb_tdc_sequencer;

    localparam int STAGES = 8;
    localparam int COARSE_W = 16;
    localparam int FINE_W = 4;
    localparam int SW = COARSE_W + FINE_W + 2;

    logic          clock = 1'b0;
    logic          reset, arm, stamp_ready;
    logic [7:0]    thermo;
    logic          tdc_reset, busy, stamp_valid;
    logic [SW-1:0] stamp_data;

    int tests = 0;
    int fails = 0;

    tdc_sequencer #(.STAGES(STAGES), .COARSE_W(COARSE_W), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .arm(arm), .thermo(thermo),
        .tdc_reset(tdc_reset), .busy(busy), .stamp_data(stamp_data),
        .stamp_valid(stamp_valid), .stamp_ready(stamp_ready)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // {busy, tdc_reset, stamp_valid}
    task automatic test_reset();
        reset = 1'b1; arm = 1'b1; stamp_ready = 1'b1; thermo = '0;
        tick(); tick();
        tests++;
        if ({busy, tdc_reset, stamp_valid, stamp_data} !== {3'b010, {SW{1'b0}}}) begin
            fails++;
            $display("FAIL reset_state: got %b_%h want 010_%h", {busy, tdc_reset, stamp_valid}, stamp_data, {SW{1'b0}});
        end
        reset = 1'b0; arm = 1'b0; stamp_ready = 1'b0;
        tick();
        tests++;
        if ({busy, tdc_reset, stamp_valid} !== 3'b010) begin
            fails++;
            $display("FAIL idle_after_reset: got %b want 010", {busy, tdc_reset, stamp_valid});
        end
    endtask

    task automatic test_basic();
        arm = 1'b1; tick(); arm = 1'b0;
        tests++;
        if ({busy, tdc_reset, stamp_valid} !== 3'b100) begin
            fails++;
            $display("FAIL basic_armed: got %b want 100", {busy, tdc_reset, stamp_valid});
        end
        repeat (3) tick();
        thermo = 8'b0001_1111; tick(); thermo = '0;
        tests++;
        if ({busy, tdc_reset, stamp_valid} !== 3'b110) begin
            fails++;
            $display("FAIL basic_capture: got %b want 110", {busy, tdc_reset, stamp_valid});
        end
        tick();
        tests++;
        if ({stamp_valid, stamp_data} !== {1'b1, 1'b0, 1'b0, 16'd3, 4'd5}) begin
            fails++;
            $display("FAIL basic_stamp: got %b_%h want 1_%h", stamp_valid, stamp_data, {1'b0, 1'b0, 16'd3, 4'd5});
        end
        stamp_ready = 1'b1; tick(); stamp_ready = 1'b0;
        tests++;
        if ({busy, tdc_reset, stamp_valid} !== 3'b010) begin
            fails++;
            $display("FAIL basic_handshake: got %b want 010", {busy, tdc_reset, stamp_valid});
        end
    endtask

    task automatic test_bubble();
        arm = 1'b1; tick(); arm = 1'b0;
        thermo = 8'b0001_0111; tick(); thermo = '0;
        tick();
        tests++;
        if ({stamp_valid, stamp_data} !== {1'b1, 1'b0, 1'b0, 16'd0, 4'd4}) begin
            fails++;
            $display("FAIL bubble_stamp: got %b_%h want 1_%h", stamp_valid, stamp_data, {1'b0, 1'b0, 16'd0, 4'd4});
        end
        stamp_ready = 1'b1; tick(); stamp_ready = 1'b0;
    endtask

    task automatic test_overflow();
        arm = 1'b1; tick(); arm = 1'b0;
        thermo = 8'hFF; tick(); thermo = '0;
        tick();
        tests++;
        if ({stamp_valid, stamp_data} !== {1'b1, 1'b0, 1'b1, 16'd0, 4'd8}) begin
            fails++;
            $display("FAIL overflow_stamp: got %b_%h want 1_%h", stamp_valid, stamp_data, {1'b0, 1'b1, 16'd0, 4'd8});
        end
        stamp_ready = 1'b1; tick(); stamp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (15) tick();
        tests++;
        if ({busy, tdc_reset, stamp_valid} !== 3'b100) begin
            fails++;
            $display("FAIL timeout_early: got %b want 100", {busy, tdc_reset, stamp_valid});
        end
        tick();
        tests++;
        if ({stamp_valid, stamp_data} !== {1'b1, 1'b1, 1'b0, 16'd15, 4'd0}) begin
            fails++;
            $display("FAIL timeout_stamp: got %b_%h want 1_%h", stamp_valid, stamp_data, {1'b1, 1'b0, 16'd15, 4'd0});
        end
        stamp_ready = 1'b1; tick(); stamp_ready = 1'b0;
        // Hit in the last ARMED cycle takes priority over the timeout.
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (15) tick();
        thermo = 8'h03; tick(); thermo = '0;
        tests++;
        if ({busy, tdc_reset, stamp_valid} !== 3'b110) begin
            fails++;
            $display("FAIL late_hit_capture: got %b want 110", {busy, tdc_reset, stamp_valid});
        end
        tick();
        tests++;
        if ({stamp_valid, stamp_data} !== {1'b1, 1'b0, 1'b0, 16'd15, 4'd2}) begin
            fails++;
            $display("FAIL late_hit_stamp: got %b_%h want 1_%h", stamp_valid, stamp_data, {1'b0, 1'b0, 16'd15, 4'd2});
        end
        stamp_ready = 1'b1; tick(); stamp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        thermo = 8'h01; tick(); thermo = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            arm = i[0];
            tick();
            tests++;
            if ({busy, stamp_valid, stamp_data} !== {2'b11, 1'b0, 1'b0, 16'd1, 4'd1}) begin
                fails++;
                $display("FAIL backpressure_hold%0d: got %b_%h want 11_%h", i, {busy, stamp_valid}, stamp_data, {1'b0, 1'b0, 16'd1, 4'd1});
            end
        end
        arm = 1'b0; stamp_ready = 1'b1; tick(); stamp_ready = 1'b0;
        tests++;
        if ({busy, tdc_reset, stamp_valid} !== 3'b010) begin
            fails++;
            $display("FAIL backpressure_release: got %b want 010", {busy, tdc_reset, stamp_valid});
        end
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_no_queue: got %b want 0", busy);
        end
    endtask

    task automatic test_midreset();
        arm = 1'b1; tick(); arm = 1'b0; tick();
        reset = 1'b1; arm = 1'b1; tick(); reset = 1'b0; arm = 1'b0;
        tests++;
        if ({busy, tdc_reset, stamp_valid, stamp_data} !== {3'b010, {SW{1'b0}}}) begin
            fails++;
            $display("FAIL reset_in_armed: got %b_%h want 010_0", {busy, tdc_reset, stamp_valid}, stamp_data);
        end
        arm = 1'b1; tick(); arm = 1'b0;
        thermo = 8'h07; tick(); thermo = '0; tick();
        reset = 1'b1; stamp_ready = 1'b1; tick(); reset = 1'b0; stamp_ready = 1'b0;
        tests++;
        if ({busy, tdc_reset, stamp_valid, stamp_data} !== {3'b010, {SW{1'b0}}}) begin
            fails++;
            $display("FAIL reset_in_present: got %b_%h want 010_0", {busy, tdc_reset, stamp_valid}, stamp_data);
        end
        thermo = 8'h01; arm = 1'b1; tick(); tick();
        tests++;
        if ({busy, tdc_reset, stamp_valid} !== 3'b010) begin
            fails++;
            $display("FAIL arm_dirty_chain: got %b want 010", {busy, tdc_reset, stamp_valid});
        end
        arm = 1'b0; thermo = '0; tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubble();
        test_overflow();
        test_timeout();
        test_backpressure();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tdc_sequencer.md
TDC_SEQUENCER -- requirements
Module: tdc_sequencer

Interface
REQ-001 SHALL have parameter STAGES, default 64: width of the thermometer code from the fine carry-chain TDC.
REQ-002 SHALL have parameter COARSE_W, default 16: coarse cycle counter width.
REQ-003 SHALL have parameter TIMEOUT, default 1024: ARMED cycles before a no-hit timeout; legal range 1..2^COARSE_W.
REQ-004 SHALL define derived FINE_W = clog2(STAGES+1).
REQ-005 SHALL have port clock, input, 1: single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port arm, input, 1: request one measurement; sampled in IDLE only.
REQ-008 SHALL have port thermo, input, STAGES: registered thermometer code from the carry chain (bit 0 = first stage).
REQ-009 SHALL have port tdc_reset, output, 1: drives the chain's capture-register reset.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port stamp_data, output, COARSE_W+FINE_W+2: packed as {timeout, overflow, coarse, fine}, timeout at MSB.
REQ-012 SHALL have port stamp_valid, output, 1: stamp_data valid.
REQ-013 SHALL have port stamp_ready, input, 1: consumer accepts stamp_data.

Function
REQ-014 SHALL implement FSM states IDLE, ARMED, CAPTURE, PRESENT; no other reachable states.
REQ-015 IDLE: tdc_reset=1; on arm=1 AND thermo==0, go to ARMED next cycle and clear coarse counter to 0; arm SHALL be ignored while thermo!=0.
REQ-016 ARMED: tdc_reset=0; coarse counter increments by 1 each ARMED cycle, starting at 0 in the first ARMED cycle.
REQ-017 ARMED, thermo!=0: snapshot thermo and current coarse value into capture registers; go to CAPTURE.
REQ-018 ARMED, thermo==0 and coarse==TIMEOUT-1: load stamp with timeout=1, overflow=0, coarse=TIMEOUT-1, fine=0; go to PRESENT.
REQ-019 REQ-017 SHALL take priority over REQ-018 when both are true in the same cycle.
REQ-020 CAPTURE (exactly 1 cycle): tdc_reset=1; fine = population count of the snapshot (bubble-tolerant, not leading-one position).
REQ-021 CAPTURE: overflow=1 iff the snapshot is all ones; timeout=0; coarse = snapshot coarse value, uncompensated for the 2-cycle chain register latency.
REQ-022 CAPTURE: go to PRESENT.
REQ-023 PRESENT: tdc_reset=1; stamp_valid=1; stamp_data SHALL be held stable until the handshake.
REQ-024 PRESENT: on stamp_valid AND stamp_ready, stamp_valid SHALL fall the next cycle and the FSM returns to IDLE; no combinational ready-to-valid path.
REQ-025 Latency: hit first visible on thermo at edge N -> stamp_valid=1 at edge N+2.
REQ-026 arm asserted in any state other than IDLE SHALL be ignored; no queuing.
REQ-027 Coarse counter SHALL never wrap within a measurement (bounded by TIMEOUT).
REQ-028 fine SHALL saturate naturally at STAGES; FINE_W SHALL hold STAGES without truncation.

Reset
REQ-029 On reset=1 at a clock edge, from any state including mid-measurement: FSM=IDLE, stamp_valid=0, stamp_data=0, coarse counter=0, capture registers=0.
REQ-030 During reset and in the following IDLE cycles: tdc_reset=1, busy=0.
REQ-031 Reset SHALL override simultaneous arm and stamp_ready.

Verification
REQ-032 With STAGES=8, TIMEOUT=16: arm in IDLE, thermo=0 for 3 ARMED cycles, then 8'b00011111 -> stamp {0,0,coarse=3,fine=5}, valid 2 cycles after the hit cycle.
REQ-033 Bubble: thermo=8'b00010111 as first nonzero sample -> fine=4, overflow=0.
REQ-034 Overflow: first nonzero thermo=8'hFF at coarse 0 -> stamp {0,1,0,8}.
REQ-035 Timeout: thermo held 0 -> stamp {1,0,15,0} after exactly 16 ARMED cycles; hit in cycle 15 instead -> normal stamp, timeout=0.
REQ-036 Backpressure: stamp_ready low 5 cycles -> stamp_data stable, arm pulses ignored, busy=1; ready high -> IDLE next cycle.
REQ-037 Reset asserted in ARMED and in PRESENT -> next cycle IDLE, stamp_valid=0, tdc_reset=1; arm with thermo!=0 in IDLE -> stays IDLE.
